// File: rtl/mux_channel_scanner.sv
// Sequential select driver for a 4:1 gate-delay mux: sweeps enabled channels,
// waits SETTLE cycles per channel, captures mux output into a 4-bit word.
module mux_channel_scanner #(
    parameter int SETTLE = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [3:0] i_chan_mask,
    input  logic       i_repeat,
    input  logic       i_mux_out,
    output logic       o_address0,
    output logic       o_address1,
    output logic       o_busy,
    output logic [3:0] o_sample,
    output logic       o_sample_valid,
    input  logic       i_sample_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

    // Returns {found, index} of the lowest set bit in mask.
    function automatic logic [2:0] first_chan(input logic [3:0] mask);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [2:0] next_chan(input logic [3:0] mask, input logic [1:0] cur);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_addr;
    logic [3:0] r_sample;
    logic [3:0] r_mask;
    logic       r_rpt;

    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] w_addr_nxt;
    logic [3:0] w_sample_nxt;
    logic [3:0] w_mask_nxt;
    logic       w_rpt_nxt;
    logic [2:0] w_first_in;
    logic [2:0] w_first_lat;
    logic [2:0] w_next;

    assign w_first_in  = first_chan(i_chan_mask);
    assign w_first_lat = first_chan(r_mask);
    assign w_next      = next_chan(r_mask, r_addr);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_sample_nxt = r_sample;
        w_mask_nxt   = r_mask;
        w_rpt_nxt    = r_rpt;
        case (r_state)
            ST_IDLE: begin
                if (i_start && (i_chan_mask != 4'b0000)) begin
                    w_mask_nxt   = i_chan_mask;
                    w_rpt_nxt    = i_repeat;
                    w_sample_nxt = 4'b0000;
                    w_addr_nxt   = w_first_in[1:0];
                    w_cnt_nxt    = 4'd0;
                    w_state_nxt  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_cnt == LP_LAST) begin
                    w_sample_nxt[r_addr] = i_mux_out;
                    w_cnt_nxt            = 4'd0;
                    // Skipping disabled channels costs no cycles: jump straight to the next enabled one.
                    if (w_next[2]) w_addr_nxt  = w_next[1:0];
                    else           w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                if (i_sample_ready) begin
                    if (r_rpt) begin
                        w_sample_nxt = 4'b0000;
                        w_addr_nxt   = w_first_lat[1:0];
                        w_cnt_nxt    = 4'd0;
                        w_state_nxt  = ST_SCAN;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= 4'd0;
            r_addr   <= 2'b00;
            r_sample <= 4'b0000;
            r_mask   <= 4'b0000;
            r_rpt    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_sample <= w_sample_nxt;
            r_mask   <= w_mask_nxt;
            r_rpt    <= w_rpt_nxt;
        end
    end

    assign o_address0     = r_addr[0];
    assign o_address1     = r_addr[1];
    assign o_sample       = r_sample;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_sample_valid = (r_state == ST_DONE);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner: three instances (SETTLE=2,3,1), each
// driving a behavioural 4:1 mux model built from its own address outputs.
module tb_mux_channel_scanner;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic       rst;
    logic [3:0] mask;
    logic       rpt;
    logic       rdy;
    logic       st0, st1, st2;
    logic [3:0] in0, in1, in2;

    logic       a0_0, a1_0, busy0, vld0, mo0;
    logic       a0_1, a1_1, busy1, vld1, mo1;
    logic       a0_2, a1_2, busy2, vld2, mo2;
    logic [3:0] smp0, smp1, smp2;
    logic [1:0] ad0, ad1, ad2;

    assign ad0 = {a1_0, a0_0};
    assign ad1 = {a1_1, a0_1};
    assign ad2 = {a1_2, a0_2};
    assign mo0 = in0[ad0];
    assign mo1 = in1[ad1];
    assign mo2 = in2[ad2];

    mux_channel_scanner #(.SETTLE(2)) u0 (
        .i_clk(clk), .i_reset(rst), .i_start(st0), .i_chan_mask(mask), .i_repeat(rpt),
        .i_mux_out(mo0), .o_address0(a0_0), .o_address1(a1_0), .o_busy(busy0),
        .o_sample(smp0), .o_sample_valid(vld0), .i_sample_ready(rdy));

    mux_channel_scanner #(.SETTLE(3)) u1 (
        .i_clk(clk), .i_reset(rst), .i_start(st1), .i_chan_mask(mask), .i_repeat(rpt),
        .i_mux_out(mo1), .o_address0(a0_1), .o_address1(a1_1), .o_busy(busy1),
        .o_sample(smp1), .o_sample_valid(vld1), .i_sample_ready(rdy));

    mux_channel_scanner #(.SETTLE(1)) u2 (
        .i_clk(clk), .i_reset(rst), .i_start(st2), .i_chan_mask(mask), .i_repeat(rpt),
        .i_mux_out(mo2), .o_address0(a0_2), .o_address1(a1_2), .o_busy(busy2),
        .o_sample(smp2), .o_sample_valid(vld2), .i_sample_ready(rdy));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] m;
        logic [3:0] in;
        logic [3:0] exp;
        int         cyc;
    } vec_t;

    vec_t       tbl[6];
    logic [3:0] rep_in[3];
    int         cnt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{4'b1111, 4'b1010, 4'b1010, 8};
        tbl[1] = '{4'b0001, 4'b1111, 4'b0001, 2};
        tbl[2] = '{4'b1000, 4'b0111, 4'b0000, 2};
        tbl[3] = '{4'b0110, 4'b1111, 4'b0110, 4};
        tbl[4] = '{4'b1101, 4'b1011, 4'b1001, 6};
        tbl[5] = '{4'b1010, 4'b1010, 4'b1010, 4};
        rep_in[0] = 4'b1001;
        rep_in[1] = 4'b1111;
        rep_in[2] = 4'b0010;

        rst = 1'b1; mask = 4'b0000; rpt = 1'b0; rdy = 1'b0;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        in0 = 4'b0000; in1 = 4'b0000; in2 = 4'b0000;

        #120;
        chk("reset_addr", {30'd0, ad0}, 32'd0);
        chk("reset_sample", {28'd0, smp0}, 32'd0);
        chk("reset_valid", {31'd0, vld0}, 32'd0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset in the middle of a sweep
        in0 = 4'b0101; mask = 4'b1111; st0 = 1'b1;
        tick();
        st0 = 1'b0;
        tick(); tick(); tick();
        chk("mid_addr", {30'd0, ad0}, 32'd1);
        chk("mid_sample", {28'd0, smp0}, 32'h1);
        chk("mid_busy", {31'd0, busy0}, 32'd1);
        #20 rst = 1'b1;
        #5;
        chk("async_rst_addr", {30'd0, ad0}, 32'd0);
        chk("async_rst_sample", {28'd0, smp0}, 32'd0);
        chk("async_rst_valid", {31'd0, vld0}, 32'd0);
        chk("async_rst_busy", {31'd0, busy0}, 32'd0);
        #10 rst = 1'b0;
        tick(); tick(); tick(); tick();
        chk("post_rst_idle", {31'd0, busy0}, 32'd0);

        // Full sweep with address trace
        in0 = 4'b1010; mask = 4'b1111; st0 = 1'b1;
        tick();
        st0 = 1'b0;
        chk("full_e0_addr", {30'd0, ad0}, 32'd0);
        chk("full_e0_busy", {31'd0, busy0}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) rdy = 1'b1;
            tick();
            chk($sformatf("full_addr_e%0d", k), {30'd0, ad0}, (k / 2 > 3) ? 32'd3 : 32'(k / 2));
            chk($sformatf("full_valid_e%0d", k), {31'd0, vld0}, (k >= 8 && k < 10) ? 32'd1 : 32'd0);
            if (k == 8) chk("full_sample", {28'd0, smp0}, 32'hA);
        end
        rdy = 1'b0;
        chk("full_busy_after", {31'd0, busy0}, 32'd0);

        // Sparse mask, SETTLE=3
        in1 = 4'b1111; mask = 4'b1001; st1 = 1'b1;
        tick();
        st1 = 1'b0;
        chk("sparse_e0_addr", {30'd0, ad1}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("sparse_addr_e%0d", k), {30'd0, ad1}, (k < 3) ? 32'd0 : 32'd3);
            chk($sformatf("sparse_valid_e%0d", k), {31'd0, vld1}, (k == 6) ? 32'd1 : 32'd0);
        end
        chk("sparse_sample", {28'd0, smp1}, 32'h9);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("sparse_busy_after", {31'd0, busy1}, 32'd0);

        // Table of single sweeps on the SETTLE=2 instance
        for (int v = 0; v < 6; v++) begin
            in0 = tbl[v].in; mask = tbl[v].m; st0 = 1'b1;
            tick();
            st0 = 1'b0;
            cnt = 0;
            while (!vld0 && cnt < 40) begin
                tick();
                cnt++;
            end
            chk($sformatf("tbl%0d_cycles", v), 32'(cnt), 32'(tbl[v].cyc));
            chk($sformatf("tbl%0d_sample", v), {28'd0, smp0}, {28'd0, tbl[v].exp});
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
            chk($sformatf("tbl%0d_idle", v), {31'd0, busy0}, 32'd0);
        end

        // Backpressure in DONE with ignored inputs
        in0 = 4'b0110; mask = 4'b1111; st0 = 1'b1;
        tick();
        st0 = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("bp_valid_start", {31'd0, vld0}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            in0  = 4'($urandom);
            st0  = 1'($urandom);
            mask = 4'($urandom);
            tick();
            chk($sformatf("bp_sample_%0d", k), {28'd0, smp0}, 32'h6);
            chk($sformatf("bp_valid_%0d", k), {31'd0, vld0}, 32'd1);
        end
        st0 = 1'b0; mask = 4'b1111; rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("bp_release_idle", {31'd0, busy0}, 32'd0);

        // Start with empty mask is ignored
        mask = 4'b0000; st0 = 1'b1;
        tick();
        st0 = 1'b0;
        chk("mask0_busy", {31'd0, busy0}, 32'd0);
        tick();
        chk("mask0_valid", {31'd0, vld0}, 32'd0);

        // Repeat mode, SETTLE=1, ready held high
        mask = 4'b0110; rpt = 1'b1; rdy = 1'b1; in2 = 4'b0110; st2 = 1'b1;
        tick();
        st2 = 1'b0;
        chk("rep_e0_addr", {30'd0, ad2}, 32'd1);
        tick();
        chk("rep_e1_valid", {31'd0, vld2}, 32'd0);
        tick();
        chk("rep_e2_valid", {31'd0, vld2}, 32'd1);
        chk("rep_e2_sample", {28'd0, smp2}, 32'h6);
        mask = 4'b1111; rpt = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in2 = rep_in[s];
            tick();
            chk($sformatf("rep%0d_hs_valid", s), {31'd0, vld2}, 32'd0);
            chk($sformatf("rep%0d_hs_addr", s), {30'd0, ad2}, 32'd1);
            chk($sformatf("rep%0d_hs_busy", s), {31'd0, busy2}, 32'd1);
            tick();
            chk($sformatf("rep%0d_mid_valid", s), {31'd0, vld2}, 32'd0);
            tick();
            chk($sformatf("rep%0d_valid", s), {31'd0, vld2}, 32'd1);
            chk($sformatf("rep%0d_sample", s), {28'd0, smp2}, {28'd0, rep_in[s] & 4'b0110});
        end
        rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_channel_scanner.md
# mux_channel_scanner

Sequential front end for the structural 4:1 multiplexer. It drives the mux `address1`/`address0` select lines through the enabled input channels in order and waits a programmable settle time on each channel. It then registers the mux `out` bit and, when the sweep ends, presents the assembled 4-bit sample word through a valid/ready handshake. The block replaces hand-driven select stimulus when the gate-delay mux is used as a scanned input port.

## Interface
Parameters:
- `SETTLE`, default 2: clock cycles per channel from address change to capture; legal range 1–15.

Ports:
- `clk`  input  1  single system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  request a sweep; honoured only in IDLE.
- `chan_mask`  input  4  enabled channels, bit i = channel i; latched on accepted `start`.
- `repeat`  input  1  latched on accepted `start`; when 1, a new sweep begins automatically after each handshake.
- `mux_out`  input  1  output of the 4:1 mux.
- `address0`  output  1  mux select bit 0, registered.
- `address1`  output  1  mux select bit 1, registered.
- `busy`  output  1  high in every state except IDLE.
- `sample`  output  4  captured word; bit i = `mux_out` seen on channel i; disabled bits read 0.
- `sample_valid`  output  1  high in DONE.
- `sample_ready`  input  1  consumer accepts `sample` when high with `sample_valid`.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `start`=1 with `chan_mask`≠0: latch mask and repeat, clear `sample` to 0, load the address with the lowest enabled channel, clear the settle counter, go to SCAN.
  - `start` with mask 0 is ignored.
- SCAN:
  - The settle counter increments each cycle.
  - On the edge where the counter equals SETTLE−1, `mux_out` is written into `sample[address]` and the counter clears.
  - If a higher enabled channel exists, the address moves to the next enabled channel in ascending order on the same edge. Disabled channels are skipped with zero cycles spent.
  - Otherwise the address holds and the state moves to DONE.
- DONE:
  - `sample` is stable and `sample_valid`=1.
  - On an edge with `sample_ready`=1 and latched repeat=0: go to IDLE.
  - On an edge with `sample_ready`=1 and latched repeat=1: perform the IDLE start actions with the latched mask and go directly to SCAN.
  - `sample_ready` is ignored outside DONE.
- `start` is ignored outside IDLE. `chan_mask` and `repeat` changes after acceptance have no effect on the current sweep or on repeats.
- In IDLE the address holds its last value.
- Counter width is 4 bits and never wraps past SETTLE−1.

## Timing
- Reset values:
  - address1/address0 = 00
  - `sample` = 0000
  - `sample_valid` = 0
  - `busy` = 0
  - state IDLE, counter 0, latched mask 0, latched repeat 0
- Start edge E0: address is valid after E0, and `busy` rises after E0.
- Capture k (k = 1..N, N = enabled count) happens at edge E0 + k·SETTLE.
- `sample_valid` rises after edge E0 + N·SETTLE.
- Throughput in repeat mode:
  - with `sample_ready` held high: one word per N·SETTLE+1 cycles;
  - the first capture of a new sweep is at handshake edge + SETTLE.
- `reset` asserted at any time, including mid-SCAN or during DONE, forces reset values asynchronously. The sweep is abandoned; after release the block waits in IDLE for a fresh `start`.
- Mux settle: SETTLE·Tclk must exceed mux propagation, which is 3 gate delays = 150 time units. With a 100-unit clock, SETTLE ≥ 2.

## Test plan
- Reset mid-sweep: after 3 cycles of SCAN assert `reset` between edges → outputs at reset values before the next edge. Release, hold `start`=0 → stays IDLE.
- Full sweep: SETTLE=2, mux inputs {in3..in0}=1010, mask=1111, repeat=0, pulse `start` at E0:
  - address sequence 0,1,2,3 changes at E0, E2, E4, E6;
  - `sample_valid` after E8 with `sample`=1010;
  - `sample_ready` at E10 → IDLE, `busy`=0.
- Sparse mask: mask=1001, inputs 1111, SETTLE=3:
  - address 0 then 3, change at E3;
  - valid after E6, `sample`=1001;
  - channels 1 and 2 never selected.
- Backpressure and ignored inputs:
  - hold `sample_ready`=0 for 20 cycles in DONE while toggling `mux_out`, `start`, `chan_mask` → `sample` constant, `sample_valid` stays 1, no restart;
  - a `start` with mask 0000 in IDLE → no state change.
- Repeat mode: mask=0110, repeat=1, SETTLE=1, `sample_ready` tied high, inputs change between sweeps:
  - a word every 3 cycles, each reflecting the current inputs on bits 1–2 with bits 0 and 3 = 0;
  - the `chan_mask` change made mid-run is not applied.
